// File: rtl/mealy_sched_pkg.sv
// Shared types and the detector next-state/output table for mealy_stream_scheduler.
package mealy_sched_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } core_state_e;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift,
      StDone
   } sched_state_e;

   typedef struct packed {
      core_state_e nxt;
      logic        z;
   } core_step_t;

   function automatic core_step_t core_table(core_state_e s, logic x);
      core_step_t r;
      r.nxt = S0;
      r.z   = 1'b0;
      unique case (s)
         S0: begin
            r.z = ~x;
            if (x) r.nxt = S2;
            else   r.nxt = S1;
         end
         S1: begin
            r.z = x;
            if (x) r.nxt = S3;
            else   r.nxt = S0;
         end
         S2: begin
            r.z = x;
            if (x) r.nxt = S3;
            else   r.nxt = S1;
         end
         S3: begin
            r.z = ~x;
            if (x) r.nxt = S2;
            else   r.nxt = S0;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mealy_detector_core.sv
// Bit-serial Mealy sequence detector: 2-bit state register plus the shared table.
module mealy_detector_core
   import mealy_sched_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [1:0] load_state,
   input  logic       step,
   input  logic       x,
   output logic       z,
   output logic [1:0] state
);

   core_state_e state_q, state_d;
   core_step_t  tbl;

   always_comb begin
      tbl     = core_table(state_q, x);
      state_d = state_q;
      if (load) begin
         state_d = core_state_e'(load_state);
      end else if (step) begin
         state_d = tbl.nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   assign z     = tbl.z;
   assign state = state_q;

endmodule

// File: rtl/mealy_stream_scheduler.sv
// Round-robin scheduler sharing one serial Mealy detector among NREQ requesters.
// Define MEALY_SCHED_CTX_EN to keep per-requester detector history across jobs.
module mealy_stream_scheduler
   import mealy_sched_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         grant,
   output logic                    busy,
   output logic [WIDTH-1:0]        result,
   output logic                    result_valid,
   output logic [IDW-1:0]          result_id
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   sched_state_e     st_q, st_d;
   logic [IDW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, rid_q, rid_d;
   logic [WIDTH-1:0] shreg_q, shreg_d, result_q, result_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic             busy_q, busy_d, valid_q, valid_d;

   logic [IDW-1:0]   pick, idx;
   logic             pick_found;
   logic [WIDTH-1:0] owner_word;
   logic             core_load, core_step, core_z;
   logic [1:0]       core_state, load_state;

   // First set request at or after rr_ptr, wrapping.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      idx        = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(rr_ptr_q) + k) % NREQ);
         if (!pick_found && req[idx]) begin
            pick_found = 1'b1;
            pick       = idx;
         end
      end
   end

   always_comb begin
      owner_word = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (owner_q == IDW'(i)) owner_word = data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      st_d      = st_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      shreg_d   = shreg_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      valid_d   = 1'b0;
      rid_d     = rid_q;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (pick_found) begin
               st_d          = StLoad;
               owner_d       = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               busy_d        = 1'b1;
            end
         end
         StLoad: begin
            shreg_d   = owner_word;
            core_load = 1'b1;
            cnt_d     = '0;
            result_d  = '0;
            st_d      = StShift;
         end
         StShift: begin
            result_d[cnt_q] = core_z;
            shreg_d         = shreg_q >> 1;
            core_step       = 1'b1;
            cnt_d           = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               st_d    = StDone;
               valid_d = 1'b1;
               rid_d   = owner_q;
            end
         end
         StDone: begin
            rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            grant_d  = '0;
            busy_d   = 1'b0;
            st_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         st_q     <= StIdle;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         shreg_q  <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         rid_q    <= '0;
      end else begin
         st_q     <= st_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         shreg_q  <= shreg_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         rid_q    <= rid_d;
      end
   end

`ifdef MEALY_SCHED_CTX_EN
   logic [1:0] ctx_q [NREQ];
   logic [1:0] ctx_d [NREQ];

   // DONE sees the core state after the last shift, i.e. the job's final state.
   always_comb begin
      ctx_d = ctx_q;
      if (st_q == StDone) ctx_d[owner_q] = core_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ctx_q <= '{default: 2'b00};
      end else begin
         ctx_q <= ctx_d;
      end
   end

   assign load_state = ctx_q[owner_q];
`else
   logic unused_core_state;
   assign unused_core_state = ^core_state;
   assign load_state        = S0;
`endif

   mealy_detector_core u_core (
      .clock      (clock),
      .reset      (reset),
      .load       (core_load),
      .load_state (load_state),
      .step       (core_step),
      .x          (shreg_q[0]),
      .z          (core_z),
      .state      (core_state)
   );

   assign grant        = grant_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = valid_q;
   assign result_id    = rid_q;

endmodule

// File: tb/tb_mealy_stream_scheduler.sv
// Self-checking bench for mealy_stream_scheduler with a job-level reference model.
module tb_mealy_stream_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;
   localparam int DW    = NREQ * WIDTH;
   localparam int DoneT = WIDTH + 1;
`ifdef MEALY_SCHED_CTX_EN
   localparam bit CtxEn = 1'b1;
`else
   localparam bit CtxEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NREQ-1:0]  req = '0;
   logic [DW-1:0]    data = '0;
   logic [NREQ-1:0]  grant;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic [IDW-1:0]   result_id;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: m_t = -1 idle, 0 LOAD, 1..WIDTH SHIFT, DoneT DONE.
   int               m_t = -1;
   int               m_owner = 0;
   int               m_rr = 0;
   int               m_fin = 0;
   int               m_ctx [NREQ];
   logic [WIDTH-1:0] m_res = '0;
   logic [WIDTH-1:0] m_last = '0;
   int               nxt0 [4] = '{1, 0, 1, 0};
   int               nxt1 [4] = '{2, 3, 3, 2};

   always #5 clk = ~clk;

   mealy_stream_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clock        (clk),
      .reset        (rst),
      .req          (req),
      .data         (data),
      .grant        (grant),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_id    (result_id)
   );

   function automatic logic [WIDTH-1:0] job_result(input int start, input logic [WIDTH-1:0] w,
                                                   output int fin);
      logic [WIDTH-1:0] r;
      int               s;
      logic             x;
      r = '0;
      s = start;
      for (int k = 0; k < WIDTH; k++) begin
         x    = w[k];
         r[k] = (s == 1 || s == 2) ? x : ~x;
         s    = x ? nxt1[s] : nxt0[s];
      end
      fin = s;
      return r;
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic p_rst, input logic [NREQ-1:0] p_req,
                             input logic [DW-1:0] p_data);
      int o;
      logic [WIDTH-1:0] w;
      if (p_rst) begin
         m_t    = -1;
         m_rr   = 0;
         m_last = '0;
         for (int i = 0; i < NREQ; i++) m_ctx[i] = 0;
      end else if (m_t < 0) begin
         o = rr_pick(p_req, m_rr);
         if (o >= 0) begin
            m_owner = o;
            m_t     = 0;
         end
      end else if (m_t == 0) begin
         w     = p_data[m_owner*WIDTH +: WIDTH];
         m_res = job_result(CtxEn ? m_ctx[m_owner] : 0, w, m_fin);
         m_t   = 1;
      end else if (m_t < DoneT) begin
         m_t++;
         if (m_t == DoneT) m_last = m_res;
      end else begin
         if (CtxEn) m_ctx[m_owner] = m_fin;
         m_rr = (m_owner + 1) % NREQ;
         m_t  = -1;
      end
   endtask

   task automatic step();
      logic             p_rst;
      logic [NREQ-1:0]  p_req;
      logic [DW-1:0]    p_data;
      p_rst  = rst;
      p_req  = req;
      p_data = data;
      @(posedge clk);
      #1;
      model_edge(p_rst, p_req, p_data);
   endtask

   task automatic do_reset(input logic [NREQ-1:0] r);
      rst = 1'b1;
      req = r;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_until_valid(input int budget, output bit seen, output int cycles);
      seen   = 1'b0;
      cycles = 0;
      for (int k = 0; k < budget; k++) begin
         step();
         if (result_valid === 1'b1) begin
            seen   = 1'b1;
            cycles = k + 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      req  = NREQ'($urandom);
      data = DW'($urandom);
      step();
      step();
      n_checks++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0", grant); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (result !== '0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
      n_checks++;
      if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", result_valid);
      else n_pass++;
      n_checks++; if (result_id !== '0) $display("FAIL reset_id: got %0d want 0", result_id); else n_pass++;
      rst = 1'b0;
      req = '0;
   endtask

   task automatic test_single();
      bit seen;
      int cyc;
      do_reset('0);
      data = DW'($urandom);
      data[0 +: WIDTH] = 8'h00;
      req = 4'b0001;
      step();
      n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", grant); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
      req = '0;
      run_until_valid(15, seen, cyc);
      n_checks++; if (!seen) $display("FAIL single_timeout: no result_valid in 15 cycles"); else n_pass++;
      n_checks++;
      if (1 + cyc != WIDTH + 2) $display("FAIL single_latency: got %0d want %0d", 1 + cyc, WIDTH + 2);
      else n_pass++;
      n_checks++; if (result !== 8'h55) $display("FAIL single_result: got %h want 55", result); else n_pass++;
      n_checks++; if (result !== m_last) $display("FAIL single_model: got %h want %h", result, m_last); else n_pass++;
      n_checks++; if (result_id !== 2'd0) $display("FAIL single_id: got %0d want 0", result_id); else n_pass++;
      step();
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || grant !== '0)
         $display("FAIL single_idle: got v=%b b=%b g=%b want 0/0/0", result_valid, busy, grant);
      else n_pass++;
      n_checks++; if (result !== 8'h55) $display("FAIL single_hold: got %h want 55", result); else n_pass++;
      data = DW'($urandom);
      data[WIDTH +: WIDTH] = 8'hFF;
      req = 4'b0010;
      step();
      n_checks++; if (grant !== 4'b0010) $display("FAIL fresh_grant: got %b want 0010", grant); else n_pass++;
      req = '0;
      run_until_valid(15, seen, cyc);
      n_checks++; if (!seen) $display("FAIL fresh_timeout: no result_valid in 15 cycles"); else n_pass++;
      n_checks++; if (result !== 8'hAA) $display("FAIL fresh_result: got %h want aa", result); else n_pass++;
      n_checks++; if (result_id !== 2'd1) $display("FAIL fresh_id: got %0d want 1", result_id); else n_pass++;
   endtask

   task automatic test_context();
      bit               seen;
      int               cyc;
      logic [WIDTH-1:0] exp2;
      exp2 = CtxEn ? 8'hAB : 8'h55;
      do_reset('0);
      data = DW'($urandom);
      data[0 +: WIDTH] = 8'hFF;
      req = 4'b0001;
      step();
      req = '0;
      run_until_valid(15, seen, cyc);
      n_checks++; if (!seen || result !== 8'hAA) $display("FAIL ctx_first: got %h seen=%b want aa", result, seen); else n_pass++;
      step();
      data[0 +: WIDTH] = 8'h00;
      req = 4'b0001;
      step();
      req = '0;
      run_until_valid(15, seen, cyc);
      n_checks++; if (!seen) $display("FAIL ctx_timeout: no result_valid in 15 cycles"); else n_pass++;
      n_checks++; if (result !== exp2) $display("FAIL ctx_second: got %h want %h", result, exp2); else n_pass++;
      n_checks++; if (result !== m_last) $display("FAIL ctx_model: got %h want %h", result, m_last); else n_pass++;
   endtask

   task automatic test_round_robin();
      int              owners [5];
      int              vcyc [5];
      int              exp_order [5];
      int              nv;
      logic [NREQ-1:0] eg;
      exp_order = '{0, 1, 2, 3, 0};
      nv = 0;
      do_reset(4'b1111);
      for (int c = 0; c < 60; c++) begin
         data = DW'($urandom);
         step();
         eg = '0;
         if (m_t >= 0) eg[m_owner] = 1'b1;
         n_checks++; if (grant !== eg) $display("FAIL rr_grant c=%0d: got %b want %b", c, grant, eg); else n_pass++;
         if (result_valid === 1'b1) begin
            n_checks++;
            if (result !== m_last) $display("FAIL rr_result c=%0d: got %h want %h", c, result, m_last);
            else n_pass++;
            if (nv < 5) begin
               owners[nv] = int'(result_id);
               vcyc[nv]   = c;
               nv++;
            end
         end
      end
      n_checks++; if (nv != 5) $display("FAIL rr_count: got %0d want 5", nv); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         if (k < nv) begin
            n_checks++;
            if (owners[k] != exp_order[k]) $display("FAIL rr_order %0d: got %0d want %0d", k, owners[k], exp_order[k]);
            else n_pass++;
            if (k > 0) begin
               n_checks++;
               if (vcyc[k] - vcyc[k-1] != WIDTH + 3)
                  $display("FAIL rr_period %0d: got %0d want %0d", k, vcyc[k] - vcyc[k-1], WIDTH + 3);
               else n_pass++;
            end
         end
      end
      req = '0;
   endtask

   task automatic test_reset_mid_job();
      bit seen;
      int cyc;
      do_reset('0);
      data = DW'($urandom);
      req  = 4'b0001;
      for (int c = 0; c < 5; c++) step();
      n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = '0;
      n_checks++;
      if (grant !== '0 || busy !== 1'b0 || result !== '0 || result_valid !== 1'b0 || result_id !== '0)
         $display("FAIL midrst_outputs: got g=%b b=%b r=%h v=%b id=%0d want all 0",
                  grant, busy, result, result_valid, result_id);
      else n_pass++;
      seen = 1'b0;
      for (int c = 0; c < 14; c++) begin
         step();
         if (result_valid === 1'b1) seen = 1'b1;
      end
      n_checks++; if (seen) $display("FAIL midrst_no_result: got a result_valid pulse want none"); else n_pass++;
      data = DW'($urandom);
      data[2*WIDTH +: WIDTH] = 8'h00;
      req = 4'b0100;
      step();
      req = '0;
      run_until_valid(15, seen, cyc);
      n_checks++; if (!seen) $display("FAIL midrst_timeout: no result_valid in 15 cycles"); else n_pass++;
      n_checks++; if (result !== 8'h55) $display("FAIL midrst_result: got %h want 55", result); else n_pass++;
      n_checks++; if (result_id !== 2'd2) $display("FAIL midrst_id: got %0d want 2", result_id); else n_pass++;
   endtask

   task automatic test_drop_data();
      int              pulses;
      logic [NREQ-1:0] eg;
      logic            ev;
      pulses = 0;
      do_reset('0);
      req = 4'b0001;
      for (int c = 0; c < 30; c++) begin
         data = DW'($urandom);
         if (c == 4) req = '0;
         step();
         eg = '0;
         if (m_t >= 0) eg[m_owner] = 1'b1;
         ev = (m_t == DoneT);
         n_checks++; if (grant !== eg) $display("FAIL drop_grant c=%0d: got %b want %b", c, grant, eg); else n_pass++;
         n_checks++;
         if (result_valid !== ev) $display("FAIL drop_valid c=%0d: got %b want %b", c, result_valid, ev);
         else n_pass++;
         if (result_valid === 1'b1) begin
            pulses++;
            n_checks++;
            if (result !== m_last) $display("FAIL drop_result: got %h want %h", result, m_last);
            else n_pass++;
         end
      end
      n_checks++; if (pulses != 1) $display("FAIL drop_pulses: got %0d want 1", pulses); else n_pass++;
   endtask

   task automatic test_random();
      logic [NREQ-1:0] eg;
      logic            ev;
      do_reset('0);
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
         data = DW'($urandom);
         rst  = ($urandom_range(0, 149) == 0);
         step();
         eg = '0;
         if (m_t >= 0) eg[m_owner] = 1'b1;
         ev = (m_t == DoneT);
         n_checks++; if (grant !== eg) $display("FAIL rand_grant c=%0d: got %b want %b", c, grant, eg); else n_pass++;
         n_checks++;
         if (busy !== (m_t >= 0)) $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, m_t >= 0);
         else n_pass++;
         n_checks++;
         if (result_valid !== ev) $display("FAIL rand_valid c=%0d: got %b want %b", c, result_valid, ev);
         else n_pass++;
         if (ev) begin
            n_checks++;
            if (result !== m_last || result_id !== IDW'(m_owner))
               $display("FAIL rand_result c=%0d: got %h/%0d want %h/%0d", c, result, result_id, m_last, m_owner);
            else n_pass++;
         end else if (m_t < 0) begin
            n_checks++;
            if (result !== m_last) $display("FAIL rand_hold c=%0d: got %h want %h", c, result, m_last);
            else n_pass++;
         end
      end
      rst = 1'b0;
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_context();
      test_round_robin();
      test_reset_mid_job();
      test_drop_data();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
